// File: rtl/addsub_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with optional signed saturation.
// Each stage resolves STAGE_GROUPS 4-bit lookahead groups; the last stage also forms flags.
module addsub_cla_pipe #(
  parameter int WIDTH        = 16,
  parameter int STAGE_GROUPS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int GROUPS = WIDTH / 4;
  localparam int STAGES = (GROUPS + STAGE_GROUPS - 1) / STAGE_GROUPS;
  localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int L      = STAGES - 1;

  // Returns carries {c4,c3,c2,c1,c0} of one 4-bit group, all derived from the group carry-in.
  function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_val(input logic a_msb);
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  function automatic void resolve_stage(
    input  int               k,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    input  logic             cin,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             c_msb
  );
    logic [3:0] p, g;
    logic [4:0] cv;
    logic       c;
    int         gi;
    c     = cin;
    s_o   = s;
    c_msb = 1'b0;
    for (int j = 0; j < STAGE_GROUPS; j++) begin
      gi = k * STAGE_GROUPS + j;
      if (gi < GROUPS) begin
        p  = a[gi*4 +: 4] ^ b[gi*4 +: 4];
        g  = a[gi*4 +: 4] & b[gi*4 +: 4];
        cv = cla4(p, g, c);
        s_o[gi*4 +: 4] = p ^ cv[3:0];
        if (gi == GROUPS - 1) c_msb = cv[3];
        c = cv[4];
      end
    end
    c_o = c;
  endfunction

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~reset;

  logic [WIDTH-1:0] st_a  [STAGES];
  logic [WIDTH-1:0] st_b  [STAGES];
  logic [WIDTH-1:0] st_s  [STAGES];
  logic [WIDTH-1:0] st_so [STAGES];
  logic             st_c  [STAGES];
  logic             st_co [STAGES];
  logic             st_cm [STAGES];
  logic             st_v  [STAGES];
  logic [1:0]       st_m  [STAGES];

  logic signed [WIDTH-1:0] a_p   [NREG];
  logic signed [WIDTH-1:0] b_p   [NREG];
  logic        [WIDTH-1:0] s_p   [NREG];
  logic                    c_p   [NREG];
  logic                    vld_p [NREG];
  logic        [1:0]       m_p   [NREG];

  // Stage 0 input: B inverted and carry-in set for subtraction at acceptance
  assign st_a[0] = in_a;
  assign st_b[0] = in_b ^ {WIDTH{in_mode[0]}};
  assign st_s[0] = '0;
  assign st_c[0] = in_mode[0];
  assign st_m[0] = in_mode;
  assign st_v[0] = in_valid & in_ready;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign st_a[k] = a_p[k-1];
    assign st_b[k] = b_p[k-1];
    assign st_s[k] = s_p[k-1];
    assign st_c[k] = c_p[k-1];
    assign st_m[k] = m_p[k-1];
    assign st_v[k] = vld_p[k-1];
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      resolve_stage(k, st_a[k], st_b[k], st_s[k], st_c[k], st_so[k], st_co[k], st_cm[k]);
    end
  end

  // Intermediate stage registers; the whole pipe freezes when adv is low
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (reset)    vld_p[k] <= 1'b0;
      else if (adv) vld_p[k] <= st_v[k];
      if (adv) begin
        a_p[k] <= st_a[k];
        b_p[k] <= st_b[k];
        s_p[k] <= st_so[k];
        c_p[k] <= st_co[k];
        m_p[k] <= st_m[k];
      end
    end
  end

  logic                    ovf, sat;
  logic signed [WIDTH-1:0] res;
  assign ovf = st_cm[L] ^ st_co[L];
  assign sat = st_m[L][1] & ovf;
  assign res = sat ? sat_val(st_a[L][WIDTH-1]) : st_so[L];

  // Last stage: flags and saturation ahead of the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
      out_neg      <= 1'b0;
    end else if (adv) begin
      out_valid    <= st_v[L];
      out_sum      <= res;
      out_carry    <= st_co[L];
      out_overflow <= ovf;
      out_zero     <= (res == '0);
      out_neg      <= res[WIDTH-1];
    end
  end

endmodule
